cdb_broadcast_arbiter: RTL and testbench

- Shares the single result-broadcast bus (the register file's broadcastDataAvailable/Tag/Data inputs) among NUM_FU execution units.
- Picks at most one completed result per cycle by round-robin and registers it onto the bus.
- Drives allowDecode low in every cycle a broadcast is on the bus, so register-file commit and decode never collide.
- Forces a decode slot after MAX_BURST back-to-back broadcasts so decode is never starved.

---
 rtl/cdb_broadcast_arbiter_pkg.sv | 14 +
 rtl/cdb_broadcast_arbiter_picker.sv | 42 ++++
 rtl/cdb_broadcast_arbiter.sv | 138 +++++++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcast_arbiter_pkg.sv
// Shared definitions for the result-broadcast arbiter: FSM encoding and the
// tag/data width defaults used by the register file and ROB.
package cdb_broadcast_arbiter_pkg;

   localparam int DEF_TAG_WIDTH  = 7;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BCAST     = 2'd1,
      ST_FORCE_DEC = 2'd2
   } cdb_state_e;

endpackage

// File: rtl/cdb_broadcast_arbiter_picker.sv
// Round-robin priority picker: rotate the request vector so rr_ptr sits at
// bit 0, priority-encode from the LSB, then map the index back.
module rr_priority_picker #(
   parameter int NUM_FU = 4,
   parameter int PTR_W  = $clog2(NUM_FU)
) (
   input  logic [NUM_FU-1:0] i_req,
   input  logic [PTR_W-1:0]  i_ptr,
   output logic [NUM_FU-1:0] o_grant,
   output logic [PTR_W-1:0]  o_idx,
   output logic              o_any
);

   logic [2*NUM_FU-1:0] w_dbl;
   logic [NUM_FU-1:0]   w_rot;
   logic [PTR_W-1:0]    w_enc;
   logic [PTR_W:0]      w_sum;
   logic [PTR_W:0]      w_wrap;

   // Doubling the vector makes the right shift a rotation for any NUM_FU.
   assign w_dbl = {i_req, i_req} >> i_ptr;
   assign w_rot = w_dbl[NUM_FU-1:0];

   // Lowest set bit of the rotated vector wins (scan downwards so it overwrites last).
   always_comb begin
      w_enc = '0;
      for (int i = NUM_FU - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_enc = PTR_W'(i);
         end else begin
            w_enc = w_enc;
         end
      end
   end

   assign w_sum   = {1'b0, w_enc} + {1'b0, i_ptr};
   assign w_wrap  = w_sum - (PTR_W+1)'(NUM_FU);
   assign o_idx   = (w_sum >= (PTR_W+1)'(NUM_FU)) ? w_wrap[PTR_W-1:0] : w_sum[PTR_W-1:0];
   assign o_any   = |i_req;
   assign o_grant = o_any ? ({{(NUM_FU-1){1'b0}}, 1'b1} << o_idx) : {NUM_FU{1'b0}};

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Result-broadcast bus arbiter: grants one finished execution unit per cycle
// round-robin, registers its tag/data onto the bus, blocks decode while the
// bus is busy and forces a decode slot after a long burst.
module cdb_broadcast_arbiter
   import cdb_broadcast_arbiter_pkg::*;
#(
   parameter int NUM_FU     = 4,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BURST  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         halt,
   input  logic                         decodeRequest,
   input  logic [NUM_FU-1:0]            fu_valid,
   input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
   input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data,
   output logic [NUM_FU-1:0]            fu_ready,
   output logic                         broadcastDataAvailable,
   output logic [TAG_WIDTH-1:0]         broadcastDestinationTag,
   output logic [DATA_WIDTH-1:0]        broadcastDestinationData,
   output logic                         allowDecode,
   output logic                         allowBroadcast
);

   localparam int PTR_W   = $clog2(NUM_FU);
   localparam int BURST_W = $clog2(MAX_BURST + 1);

   cdb_state_e             r_state;
   cdb_state_e             w_state_nxt;
   logic [PTR_W-1:0]       r_rr_ptr;
   logic [BURST_W-1:0]     r_burst_cnt;
   logic                   r_bcast_valid;
   logic [TAG_WIDTH-1:0]   r_bcast_tag;
   logic [DATA_WIDTH-1:0]  r_bcast_data;

   logic [NUM_FU-1:0]      w_pick_onehot;
   logic [PTR_W-1:0]       w_pick_idx;
   logic                   w_pick_any;
   logic                   w_burst_full;
   logic                   w_grant_en;
   logic                   w_grant;

   rr_priority_picker #(
      .NUM_FU (NUM_FU),
      .PTR_W  (PTR_W)
   ) u_picker (
      .i_req   (fu_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick_onehot),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_burst_full = (r_burst_cnt == BURST_W'(MAX_BURST));
   assign w_grant_en   = ~halt & ~(w_burst_full & decodeRequest);
   assign w_grant      = w_grant_en & w_pick_any & ~rst;

   assign fu_ready                 = w_grant ? w_pick_onehot : {NUM_FU{1'b0}};
   assign allowBroadcast           = w_grant_en;
   assign allowDecode              = ~r_bcast_valid & ~halt;
   assign broadcastDataAvailable   = r_bcast_valid;
   assign broadcastDestinationTag  = r_bcast_tag;
   assign broadcastDestinationData = r_bcast_data;

   // Next-state: the same rules apply from every state; only the grant and burst matter.
   always_comb begin
      w_state_nxt = ST_IDLE;
      case (r_state)
         ST_IDLE, ST_BCAST, ST_FORCE_DEC: begin
            if (w_grant) begin
               w_state_nxt = ST_BCAST;
            end else if (w_burst_full && decodeRequest) begin
               w_state_nxt = ST_FORCE_DEC;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bus register: capture the granted unit's result for exactly one cycle; tag/data hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcast_valid <= 1'b0;
         r_bcast_tag   <= '0;
         r_bcast_data  <= '0;
      end else if (w_grant) begin
         r_bcast_valid <= 1'b1;
         r_bcast_tag   <= fu_tag[w_pick_idx*TAG_WIDTH +: TAG_WIDTH];
         r_bcast_data  <= fu_data[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         r_bcast_valid <= 1'b0;
      end
   end

   // Round-robin pointer: move just past the winner, wrapping at the last unit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_grant) begin
         if (w_pick_idx == PTR_W'(NUM_FU - 1)) begin
            r_rr_ptr <= '0;
         end else begin
            r_rr_ptr <= w_pick_idx + PTR_W'(1);
         end
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end

   // Burst counter: counts back-to-back grants while decode is waiting, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_burst_cnt <= '0;
      end else if (w_grant && decodeRequest) begin
         if (w_burst_full) begin
            r_burst_cnt <= r_burst_cnt;
         end else begin
            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
         end
      end else begin
         r_burst_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed bench for cdb_broadcast_arbiter (NUM_FU=4, TAG 7, DATA 32, MAX_BURST 4).
module tb_cdb_broadcast_arbiter;

   logic         clk;
   logic         rst;
   logic         halt;
   logic         decodeRequest;
   logic [3:0]   fu_valid;
   logic [27:0]  fu_tag;
   logic [127:0] fu_data;
   logic [3:0]   fu_ready;
   logic         broadcastDataAvailable;
   logic [6:0]   broadcastDestinationTag;
   logic [31:0]  broadcastDestinationData;
   logic         allowDecode;
   logic         allowBroadcast;

   int n_cmp;
   int n_bad;

   cdb_broadcast_arbiter #(
      .NUM_FU(4), .TAG_WIDTH(7), .DATA_WIDTH(32), .MAX_BURST(4)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .halt                     (halt),
      .decodeRequest            (decodeRequest),
      .fu_valid                 (fu_valid),
      .fu_tag                   (fu_tag),
      .fu_data                  (fu_data),
      .fu_ready                 (fu_ready),
      .broadcastDataAvailable   (broadcastDataAvailable),
      .broadcastDestinationTag  (broadcastDestinationTag),
      .broadcastDestinationData (broadcastDestinationData),
      .allowDecode              (allowDecode),
      .allowBroadcast           (allowBroadcast)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge, apply inputs, settle.
   task automatic step(input logic [3:0] v, input logic dreq, input logic h);
      @(negedge clk);
      fu_valid      = v;
      decodeRequest = dreq;
      halt          = h;
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; halt = 1'b0; decodeRequest = 1'b0;
      fu_valid = 4'b1111; fu_tag = '0; fu_data = '0;
      #12;
      // Reset state, requests present but gated by reset.
      chk("rst_ready", fu_ready, 4'b0000);
      chk("rst_avail", broadcastDataAvailable, 1'b0);
      chk("rst_tag", broadcastDestinationTag, 7'h00);
      chk("rst_data", broadcastDestinationData, 32'h0);
      chk("rst_ptr", dut.r_rr_ptr, 2'd0);
      chk("rst_state", dut.r_state, 2'd0);

      // Single grant to unit 2.
      fu_tag[20:14]   = 7'h15;
      fu_data[95:64]  = 32'hDEADBEEF;
      @(negedge clk);
      rst = 1'b0;
      fu_valid = 4'b0100;
      #1;
      chk("t1_ready", fu_ready, 4'b0100);
      chk("t1_allowbc", allowBroadcast, 1'b1);
      chk("t1_dec_pre", allowDecode, 1'b1);
      step(4'b0000, 1'b0, 1'b0);
      chk("t1_avail", broadcastDataAvailable, 1'b1);
      chk("t1_tag", broadcastDestinationTag, 7'h15);
      chk("t1_data", broadcastDestinationData, 32'hDEADBEEF);
      chk("t1_dec_busy", allowDecode, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      chk("t1_avail_off", broadcastDataAvailable, 1'b0);
      chk("t1_dec_free", allowDecode, 1'b1);
      chk("t1_ptr", dut.r_rr_ptr, 2'd3);
      chk("t1_tag_hold", broadcastDestinationTag, 7'h15);

      // Distinct tags/data per unit: tag 10+i, data A0+i.
      for (int i = 0; i < 4; i++) begin
         fu_tag[i*7 +: 7]   = 7'h10 + 7'(i);
         fu_data[i*32 +: 32] = 32'hA0 + 32'(i);
      end

      // Wrap: rr_ptr=3, units 0 and 1 requesting -> 0 then 1.
      step(4'b0011, 1'b0, 1'b0);
      chk("wr_ready0", fu_ready, 4'b0001);
      step(4'b0010, 1'b0, 1'b0);
      chk("wr_ready1", fu_ready, 4'b0010);
      chk("wr_ptr1", dut.r_rr_ptr, 2'd1);
      chk("wr_tag0", broadcastDestinationTag, 7'h10);
      step(4'b1000, 1'b0, 1'b0);
      chk("wr_tag1", broadcastDestinationTag, 7'h11);
      chk("wr_ready3", fu_ready, 4'b1000);
      step(4'b0000, 1'b0, 1'b0);
      chk("wr_data3", broadcastDestinationData, 32'hA3);
      chk("wr_ptr0", dut.r_rr_ptr, 2'd0);

      // All four requesting, no decode pressure: strict rotation 0..3.
      for (int k = 0; k < 4; k++) begin
         step(4'b1111, 1'b0, 1'b0);
         chk("rot_ready", fu_ready, 4'b0001 << k);
         if (k > 0) begin
            chk("rot_avail", broadcastDataAvailable, 1'b1);
            chk("rot_tag", broadcastDestinationTag, 7'h10 + 7'(k - 1));
         end
      end
      step(4'b0000, 1'b0, 1'b0);
      chk("rot_tag_last", broadcastDestinationTag, 7'h13);
      chk("rot_ptr", dut.r_rr_ptr, 2'd0);

      // Burst limit with decode waiting.
      for (int k = 0; k < 4; k++) begin
         step(4'b1111, 1'b1, 1'b0);
         chk("bu_ready", fu_ready, 4'b0001 << k);
         chk("bu_allowbc", allowBroadcast, 1'b1);
      end
      step(4'b1111, 1'b1, 1'b0);
      chk("bu_block_ready", fu_ready, 4'b0000);
      chk("bu_block_allowbc", allowBroadcast, 1'b0);
      chk("bu_block_dec", allowDecode, 1'b0);
      step(4'b1111, 1'b1, 1'b0);
      chk("bu_fd_state", dut.r_state, 2'd2);
      chk("bu_fd_dec", allowDecode, 1'b1);
      chk("bu_fd_avail", broadcastDataAvailable, 1'b0);
      chk("bu_resume", fu_ready, 4'b0001);
      step(4'b0000, 1'b0, 1'b0);
      chk("bu_resume_tag", broadcastDestinationTag, 7'h10);

      // Halt: in-flight broadcast completes, no new grant until release.
      step(4'b0010, 1'b0, 1'b0);
      chk("h_ready1", fu_ready, 4'b0010);
      step(4'b0001, 1'b0, 1'b1);
      chk("h_avail", broadcastDataAvailable, 1'b1);
      chk("h_tag", broadcastDestinationTag, 7'h11);
      chk("h_ready_blk", fu_ready, 4'b0000);
      chk("h_dec", allowDecode, 1'b0);
      chk("h_allowbc", allowBroadcast, 1'b0);
      step(4'b0001, 1'b0, 1'b1);
      chk("h_avail2", broadcastDataAvailable, 1'b0);
      chk("h_ready_blk2", fu_ready, 4'b0000);
      chk("h_dec2", allowDecode, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      chk("h_release", fu_ready, 4'b0001);
      chk("h_dec3", allowDecode, 1'b1);
      step(4'b0000, 1'b0, 1'b0);
      chk("h_tag0", broadcastDestinationTag, 7'h10);

      // Reset in the middle of a broadcast cycle.
      step(4'b0100, 1'b0, 1'b0);
      chk("r_ready2", fu_ready, 4'b0100);
      step(4'b1111, 1'b0, 1'b0);
      chk("r_avail_pre", broadcastDataAvailable, 1'b1);
      rst = 1'b1;
      #1;
      chk("r_avail_async", broadcastDataAvailable, 1'b0);
      chk("r_ready_rst", fu_ready, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      fu_valid = 4'b0000;
      #1;
      chk("r_ptr", dut.r_rr_ptr, 2'd0);
      chk("r_state", dut.r_state, 2'd0);
      chk("r_tag", broadcastDestinationTag, 7'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
